// File: rtl/dda_state_reader_if.sv
// Byte-stream output port of the DDA state reader: valid/ready with a start-of-frame marker.
interface dda_state_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_sof;

    modport master (output out_data, output out_valid, output frame_sof, input out_ready);
    modport slave  (input out_data, input out_valid, input frame_sof, output out_ready);
endinterface

// File: rtl/dda_state_reader.sv
// Samples DDA state {x,y} on a decimation schedule and streams A5/seq/x/y byte frames.
// Optional trailing CRC-8 byte (poly 0x07) when DDA_READOUT_CRC_EN is defined.
module dda_state_reader #(
    parameter int N       = 16,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DECIM_W-1:0] decim,
    input  logic [N-1:0]       x,
    input  logic [N-1:0]       y,
    dda_state_reader_if.master o,
    output logic               busy,
    output logic               overrun
);
    localparam int NB  = N / 8;
    localparam int FB  = 2 + 2 * NB;
    localparam int SRW = 8 * FB;
    localparam int IW  = $clog2(FB + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef DDA_READOUT_CRC_EN
    localparam logic [1:0] ST_CRC  = 2'd2;
`endif

    logic [1:0]         state_q, state_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [SRW-1:0]     sr_q, sr_d;
    logic [7:0]         seq_q, seq_d;
    logic               overrun_q, overrun_d;
    logic               trig, hs, last_byte, frame_end, accept;

`ifdef DDA_READOUT_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    assign o.out_valid = (state_q != ST_IDLE);
    assign o.frame_sof = o.out_valid && (idx_q == '0);
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;

    // The CRC byte is not held in the shift register; it is muxed in from the CRC register.
`ifdef DDA_READOUT_CRC_EN
    assign o.out_data = (state_q == ST_CRC) ? crc_q : sr_q[SRW-1 -: 8];
`else
    assign o.out_data = sr_q[SRW-1 -: 8];
`endif

    always_comb begin
        trig      = en && (dcnt_q == decim);
        hs        = o.out_valid && o.out_ready;
        last_byte = (state_q == ST_SEND) && (idx_q == IW'(FB - 1));
`ifdef DDA_READOUT_CRC_EN
        frame_end = hs && (state_q == ST_CRC);
`else
        frame_end = hs && last_byte;
`endif
        accept    = trig && ((state_q == ST_IDLE) || frame_end);
    end

    always_comb begin
        dcnt_d    = dcnt_q;
        state_d   = state_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        seq_d     = seq_q;
        overrun_d = overrun_q | (trig & ~accept);
`ifdef DDA_READOUT_CRC_EN
        crc_d     = crc_q;
`endif

        // decim is compared live; lowering it below dcnt lets the counter run to wrap
        if (en)
            dcnt_d = trig ? '0 : dcnt_q + 1'b1;

        case (state_q)
            ST_SEND: begin
                if (hs) begin
                    sr_d  = sr_q << 8;
                    idx_d = idx_q + 1'b1;
`ifdef DDA_READOUT_CRC_EN
                    crc_d = crc8_byte(crc_q, sr_q[SRW-1 -: 8]);
                    if (last_byte)
                        state_d = ST_CRC;
`else
                    if (last_byte)
                        state_d = ST_IDLE;
`endif
                end
            end
`ifdef DDA_READOUT_CRC_EN
            ST_CRC: begin
                if (hs)
                    state_d = ST_IDLE;
            end
`endif
            default: ;
        endcase

        // A capture on the final handshake overrides the return to IDLE: no gap between frames
        if (accept) begin
            sr_d    = {8'hA5, seq_q, x, y};
            idx_d   = '0;
            state_d = ST_SEND;
            seq_d   = seq_q + 8'd1;
`ifdef DDA_READOUT_CRC_EN
            crc_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            seq_q     <= 8'h00;
            overrun_q <= 1'b0;
`ifdef DDA_READOUT_CRC_EN
            crc_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
`ifdef DDA_READOUT_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end
endmodule

// File: tb/tb_dda_state_reader.sv
// Directed bench for dda_state_reader (N=16): latency, backpressure, en gating,
// back-to-back frames with seq wrap, and mid-frame reset.
module tb_dda_state_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [7:0]  decim = 8'd9;
    logic [15:0] x = 16'h4000;
    logic [15:0] y = 16'h0000;
    logic        busy, overrun;
    int          total = 0;
    int          bad   = 0;

    typedef logic [7:0] frame_t [8];

`ifdef DDA_READOUT_CRC_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif

    dda_state_reader_if bus ();

    dda_state_reader #(.N(16), .DECIM_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .decim(decim), .x(x), .y(y),
        .o(bus), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] crc_bit_serial(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[7] ^ d[i]) r = (r << 1) ^ 8'h07;
            else             r = r << 1;
        end
        return r;
    endfunction

    function automatic frame_t mk(input logic [7:0] s, input logic [15:0] xv, input logic [15:0] yv);
        frame_t f;
        logic [7:0] c;
        f[0] = 8'hA5; f[1] = s;
        f[2] = xv[15:8]; f[3] = xv[7:0];
        f[4] = yv[15:8]; f[5] = yv[7:0];
        c = 8'h00;
        for (int i = 0; i < 6; i++) c = crc_bit_serial(c, f[i]);
        f[6] = c; f[7] = 8'h00;
        return f;
    endfunction

    // Receive one frame; out_ready drawn randomly when rnd=1. A stalled byte must match e[k].
    task automatic recv(input frame_t e, input bit rnd, input bit nogap, input string tag);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        if (nogap) chk({tag, " no_gap"}, {31'd0, bus.out_valid}, 32'd1);
        while (k < FL && cyc < 400) begin
            if (bus.out_valid) begin
                chk($sformatf("%s byte%0d", tag, k), {24'd0, bus.out_data}, {24'd0, e[k]});
                chk($sformatf("%s sof%0d", tag, k), {31'd0, bus.frame_sof}, (k == 0) ? 32'd1 : 32'd0);
            end else if (k > 0) begin
                chk($sformatf("%s valid_drop%0d", tag, k), 32'd0, 32'd1);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) k++;
            step(1);
            cyc++;
        end
        chk({tag, " bytes_done"}, k, FL);
    endtask

    task automatic wait_busy(input string tag);
        int cyc = 0;
        while (!busy && cyc < 300) begin
            step(1);
            cyc++;
        end
        chk({tag, " wait_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        frame_t f1;
        int     cnt;
        bus.out_ready = 1'b1;

        // 1: reset state and first-frame latency
        step(2);
        chk("rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        chk("rst data", {24'd0, bus.out_data}, 32'd0);
        chk("rst sof", {31'd0, bus.frame_sof}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        step(9);
        chk("t1 valid_before_10th", {31'd0, bus.out_valid}, 32'd0);
        step(1);
        chk("t1 valid_after_10th", {31'd0, bus.out_valid}, 32'd1);
        f1[0] = 8'hA5; f1[1] = 8'h00; f1[2] = 8'h40; f1[3] = 8'h00;
        f1[4] = 8'h00; f1[5] = 8'h00; f1[6] = 8'hC1; f1[7] = 8'h00;
        recv(f1, 1'b0, 1'b0, "t1");
        chk("t1 idle", {31'd0, busy}, 32'd0);
        chk("t1 overrun", {31'd0, overrun}, 32'd0);

        // 3: random backpressure, seq 01
        x = 16'h1234; y = 16'hABCD;
        bus.out_ready = 1'b0;
        wait_busy("t3");
        en = 1'b0;
        recv(mk(8'h01, 16'h1234, 16'hABCD), 1'b1, 1'b0, "t3");
        chk("t3 idle", {31'd0, busy}, 32'd0);
        chk("t3 overrun", {31'd0, overrun}, 32'd0);

        // 5: en dropped mid-frame freezes the counter at 2
        decim = 8'd20; en = 1'b1; x = 16'h7F01; y = 16'h80FE;
        bus.out_ready = 1'b0;
        wait_busy("t5");
        step(2);
        chk("t5 stall data", {24'd0, bus.out_data}, 32'h0000_00A5);
        chk("t5 stall valid", {31'd0, bus.out_valid}, 32'd1);
        en = 1'b0;
        recv(mk(8'h02, 16'h7F01, 16'h80FE), 1'b0, 1'b0, "t5a");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) cnt++;
            step(1);
        end
        chk("t5 no_header_while_en0", cnt, 0);
        en = 1'b1;
        step(18);
        chk("t5 valid_before_remaining", {31'd0, bus.out_valid}, 32'd0);
        step(1);
        chk("t5 valid_after_remaining", {31'd0, bus.out_valid}, 32'd1);
        en = 1'b0;
        recv(mk(8'h03, 16'h7F01, 16'h80FE), 1'b0, 1'b0, "t5b");
        chk("t5 overrun", {31'd0, overrun}, 32'd0);

        // 4: decim=0 back-to-back frames, overrun, seq wrap
        decim = 8'd0; en = 1'b1; x = 16'hC3C3; y = 16'h0101;
        step(1);
        chk("t4 first_header", {31'd0, bus.out_valid}, 32'd1);
        chk("t4 overrun_at_accept", {31'd0, overrun}, 32'd0);
        recv(mk(8'h04, 16'hC3C3, 16'h0101), 1'b0, 1'b0, "t4_04");
        chk("t4 overrun_sticky", {31'd0, overrun}, 32'd1);
        for (int f = 1; f <= 253; f++)
            recv(mk(8'(4 + f), 16'hC3C3, 16'h0101), 1'b0, 1'b1, $sformatf("t4_%02h", 8'(4 + f)));

        // 6: reset at byte index 3 of the seq-02 frame
        chk("t6 sof", {31'd0, bus.frame_sof}, 32'd1);
        step(3);
        chk("t6 idx3_data", {24'd0, bus.out_data}, 32'h0000_00C3);
        rst = 1'b1;
        step(1);
        chk("t6 valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6 busy", {31'd0, busy}, 32'd0);
        chk("t6 overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step(1);
        en = 1'b0;
        recv(mk(8'h00, 16'hC3C3, 16'h0101), 1'b0, 1'b0, "t6");
        chk("t6 overrun_end", {31'd0, overrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
